// File: rtl/fa4_lookup_buffer_pkg.sv
// Shared types and constants for the 4-entry fully associative lookup buffer.
// FSM state encoding, way count and the free-way priority helper live here.
package fa4_lookup_buffer_pkg;
  localparam int WAYS  = 4;
  localparam int WAY_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MREQ  = 2'd1,
    ST_MWAIT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Lowest-index invalid way; only meaningful when at least one way is free.
  function automatic logic [WAY_W-1:0] first_free(input logic [WAYS-1:0] valid);
    first_free = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) first_free = WAY_W'(i);
    end
  endfunction
endpackage

// File: rtl/fa4_lookup_buffer_if.sv
// Lookup, response and refill-memory signals of fa4_lookup_buffer.
// slave = the buffer itself, master = the requester / memory model side.
interface fa4_lookup_buffer_if #(
  parameter int TAG_W  = 20,
  parameter int DATA_W = 32
);
  logic              i_lkp_valid;
  logic              o_lkp_ready;
  logic [TAG_W-1:0]  i_lkp_tag;
  logic              o_rsp_valid;
  logic              o_rsp_hit;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_mem_req_valid;
  logic              i_mem_req_ready;
  logic [TAG_W-1:0]  o_mem_req_tag;
  logic              i_mem_rsp_valid;
  logic [DATA_W-1:0] i_mem_rsp_data;

  modport slave (
    input  i_lkp_valid, i_lkp_tag, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
    output o_lkp_ready, o_rsp_valid, o_rsp_hit, o_rsp_data, o_mem_req_valid, o_mem_req_tag
  );

  modport master (
    output i_lkp_valid, i_lkp_tag, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
    input  o_lkp_ready, o_rsp_valid, o_rsp_hit, o_rsp_data, o_mem_req_valid, o_mem_req_tag
  );
endinterface

// File: rtl/gnrl_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset to zero.
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    qout <= '0;
    else if (lden) qout <= dnxt;
  end
endmodule

// File: rtl/plru4_module.sv
// 4-way tree pseudo-LRU: bit0 picks the victim half, bit1/bit2 the way within it.
module plru4_module (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit,
  input  logic [1:0] hit_idx,
  input  logic       req,
  output logic [1:0] replace_idx
);
  logic [2:0] tree_q;
  logic [2:0] tree_d;
  logic [1:0] touch_idx;

  assign replace_idx = tree_q[0] ? {1'b1, tree_q[2]} : {1'b0, tree_q[1]};
  assign touch_idx   = hit ? hit_idx : replace_idx;

  // Touching a way turns every node on its path to point away from it.
  always_comb begin
    tree_d    = tree_q;
    tree_d[0] = ~touch_idx[1];
    if (touch_idx[1]) tree_d[2] = ~touch_idx[0];
    else              tree_d[1] = ~touch_idx[0];
  end

  gnrl_dfflr #(.DW(3)) u_tree (
    .clk(clk), .rst_n(rst_n), .lden(hit | req), .dnxt(tree_d), .qout(tree_q)
  );
endmodule

// File: rtl/fa4_lookup_buffer.sv
// 4-entry fully associative lookup buffer with single-outstanding refill and tree PLRU.
// Optional FA4_LOOKUP_BUFFER_FLUSH_EN adds i_flush to invalidate all entries.
module fa4_lookup_buffer
  import fa4_lookup_buffer_pkg::*;
#(
  parameter int TAG_W  = 20,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef FA4_LOOKUP_BUFFER_FLUSH_EN
  input  logic i_flush,
`endif
  fa4_lookup_buffer_if.slave bus
);
  state_e            state_q, state_d;
  logic [1:0]        state_raw;
  logic [WAYS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_mem  [WAYS];
  logic [DATA_W-1:0] data_mem [WAYS];
  logic [TAG_W-1:0]  miss_tag_q;
  logic              rsp_valid_q, rsp_hit_q, rsp_valid_d, rsp_hit_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              flush, lkp_ready, accept, lkp_hit, refill, any_free;
  logic [WAY_W-1:0]  hit_way, free_way, victim_way, fill_way;
  logic              plru_hit, plru_req;
  logic [WAY_W-1:0]  plru_hit_idx;

`ifdef FA4_LOOKUP_BUFFER_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    lkp_hit = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && tag_mem[i] == bus.i_lkp_tag) begin
        lkp_hit = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

  assign lkp_ready = (state_q == ST_IDLE) && !flush;
  assign accept    = bus.i_lkp_valid && lkp_ready;
  assign refill    = (state_q == ST_MWAIT) && bus.i_mem_rsp_valid;
  assign any_free  = ~&valid_q;
  assign free_way  = first_free(valid_q);
  assign fill_way  = any_free ? free_way : victim_way;

  // Exactly one PLRU update per access: hit-touch for hits and free-way fills,
  // replace-request only when the victim is evicted.
  assign plru_hit     = (accept && lkp_hit) || (refill && any_free);
  assign plru_hit_idx = refill ? free_way : hit_way;
  assign plru_req     = refill && !any_free;

  plru4_module u_plru (
    .clk(clk), .rst_n(rst_n), .hit(plru_hit), .hit_idx(plru_hit_idx),
    .req(plru_req), .replace_idx(victim_way)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !lkp_hit) state_d = ST_MREQ;
      ST_MREQ:  if (bus.i_mem_req_ready) state_d = ST_MWAIT;
      ST_MWAIT: if (bus.i_mem_rsp_valid) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  gnrl_dfflr #(.DW(2)) u_state (
    .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(state_d), .qout(state_raw)
  );
  assign state_q = state_e'(state_raw);

  // Flush clears first so a refill landing on the same edge still installs its entry.
  always_comb begin
    valid_d = flush ? '0 : valid_q;
    if (refill) valid_d[fill_way] = 1'b1;
  end

  gnrl_dfflr #(.DW(WAYS)) u_valid (
    .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(valid_d), .qout(valid_q)
  );

  gnrl_dfflr #(.DW(TAG_W)) u_miss_tag (
    .clk(clk), .rst_n(rst_n), .lden(accept && !lkp_hit), .dnxt(bus.i_lkp_tag), .qout(miss_tag_q)
  );

  always_ff @(posedge clk) begin
    if (refill) begin
      tag_mem[fill_way]  <= miss_tag_q;
      data_mem[fill_way] <= bus.i_mem_rsp_data;
    end
  end

  assign rsp_valid_d = (accept && lkp_hit) || refill;
  assign rsp_hit_d   = accept && lkp_hit;
  assign rsp_data_d  = refill ? bus.i_mem_rsp_data : data_mem[hit_way];

  gnrl_dfflr #(.DW(2)) u_rsp_ctl (
    .clk(clk), .rst_n(rst_n), .lden(1'b1),
    .dnxt({rsp_valid_d, rsp_hit_d}), .qout({rsp_valid_q, rsp_hit_q})
  );

  gnrl_dfflr #(.DW(DATA_W)) u_rsp_data (
    .clk(clk), .rst_n(rst_n), .lden(rsp_valid_d), .dnxt(rsp_data_d), .qout(rsp_data_q)
  );

  assign bus.o_lkp_ready     = lkp_ready;
  assign bus.o_rsp_valid     = rsp_valid_q;
  assign bus.o_rsp_hit       = rsp_valid_q && rsp_hit_q;
  assign bus.o_rsp_data      = rsp_valid_q ? rsp_data_q : '0;
  assign bus.o_mem_req_valid = (state_q == ST_MREQ);
  assign bus.o_mem_req_tag   = miss_tag_q;
endmodule

// File: doc/fa4_lookup_buffer.md
FA4_LOOKUP_BUFFER -- requirements
Module: fa4_lookup_buffer

Interface
REQ-001 SHALL have parameter TAG_W, default 20, lookup tag width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, entry data width in bits.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have i_lkp_valid  input  1  lookup request present.
REQ-006 SHALL have o_lkp_ready  output  1  lookup accepted when valid & ready.
REQ-007 SHALL have i_lkp_tag  input  TAG_W  lookup tag.
REQ-008 SHALL have o_rsp_valid  output  1  one-cycle response pulse, no backpressure.
REQ-009 SHALL have o_rsp_hit  output  1  response was a hit (1) or refilled (0).
REQ-010 SHALL have o_rsp_data  output  DATA_W  response data.
REQ-011 SHALL have o_mem_req_valid / i_mem_req_ready  output/input  1  refill request handshake.
REQ-012 SHALL have o_mem_req_tag  output  TAG_W  missing tag, stable while o_mem_req_valid.
REQ-013 SHALL have i_mem_rsp_valid  input  1, i_mem_rsp_data  input  DATA_W  refill return, always accepted.

Function
REQ-014 SHALL hold 4 entries {valid, tag, data}; fully associative; hit = valid & tag equal (at most one match by construction).
REQ-015 SHALL run FSM IDLE -> (miss accepted) MREQ -> (i_mem_req_ready) MWAIT -> (i_mem_rsp_valid) RESP -> IDLE; hit accepted stays IDLE.
REQ-016 SHALL drive o_lkp_ready=1 only in IDLE; one lookup outstanding max.
REQ-017 Hit: o_rsp_valid=1, o_rsp_hit=1, o_rsp_data=entry data exactly 1 cycle after acceptance.
REQ-018 Miss: o_mem_req_valid=1 from cycle after acceptance until handshake; tag latched at acceptance.
REQ-019 Refill: on i_mem_rsp_valid in MWAIT, write {1, latched tag, data} into lowest-index invalid way, else PLRU victim; RESP cycle drives o_rsp_valid=1, o_rsp_hit=0, o_rsp_data=refill data.
REQ-020 i_mem_rsp_valid outside MWAIT SHALL be ignored; lookup on same tag as in-flight miss impossible (ready low).
REQ-021 Replacement state SHALL be a 4-way tree PLRU (3 bits): hit pulses hit-update with hit way; refill into invalid way pulses hit-update with that way; refill into victim pulses replace-request; exactly one update per access.
REQ-022 o_rsp_data SHALL be zero when o_rsp_valid=0.

Reset
REQ-023 On rst_n low: all valid bits 0, PLRU state 0, FSM IDLE, o_rsp_valid/o_mem_req_valid/o_rsp_hit 0, data outputs 0; o_lkp_ready 1 after release.
REQ-024 Reset during MREQ/MWAIT SHALL abandon the refill; no entry written; no response issued.

Configuration
REQ-025 Macro FA4_LOOKUP_BUFFER_FLUSH_EN: when defined, input i_flush (1 bit) exists; i_flush high clears all valid bits next edge and forces o_lkp_ready=0 that cycle (flush wins over simultaneous lookup); in-flight refill still completes and writes its entry; PLRU state unaffected. When undefined, no port, entries invalidated only by reset.

Structure
REQ-026 Shared package SHALL hold FSM state encoding (IDLE, MREQ, MWAIT, RESP) and constant WAYS=4.
REQ-027 Replacement SHALL be instantiated from existing plru4_module (hit, hit_idx, req, replace_idx); state registers via gnrl_dfflr.

Verification
REQ-028 Reset, lookup tag 0x00010 -> mem req tag 0x00010; rsp data 0xDEADBEEF -> o_rsp_valid, hit=0, data 0xDEADBEEF, way0 written.
REQ-029 Repeat lookup 0x00010 -> o_rsp_valid next cycle, hit=1, data 0xDEADBEEF, no mem req.
REQ-030 Fill tags 0x1..0x4 (ways 0..3), hit 0x1, 0x3, then miss 0x5 -> PLRU victim way 1 replaced; later 0x2 misses, 0x1 hits.
REQ-031 i_mem_req_ready held low 10 cycles -> o_mem_req_valid and tag stable all 10 cycles, o_lkp_ready 0.
REQ-032 rst_n low during MWAIT, then rsp arrives -> ignored, no entry, no o_rsp_valid.
REQ-033 With FA4_LOOKUP_BUFFER_FLUSH_EN: i_flush with lookup 0x1 same cycle -> lookup not accepted; next lookup 0x1 misses.
